// File: rtl/bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
//
// Multi-digit decimal up/down counter with a built-in tick prescaler.
// Produces packed BCD digits (digit 0 in bits [3:0]) for per-digit
// BCD-to-seven-segment decoders. A single clock domain is used; counting is
// paced by an internal enable tick rather than a divided clock.
//
// Parameters:
//   DIGITS   - number of BCD digits (1..8)
//   TICK_DIV - enabled clk_in cycles per count step (>= 1)
//
// Ports:
//   clk_in    in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   en        in   count enable, gates the prescaler
//   up_dn     in   1 = count up, 0 = count down (used on the step edge)
//   clr       in   synchronous clear (highest priority)
//   load      in   synchronous load of load_val (nibbles > 9 load as 0)
//   load_val  in   load value, packed BCD
//   bcd_out   out  current count, packed BCD
//   tick_out  out  one-cycle pulse on each count step
//   carry     out  one-cycle pulse on wrap (carry up / borrow down)
//
// Configuration macro:
//   BCD_COUNTER_SATURATE_EN - when defined, the count holds at all 9s (up)
//   or all 0s (down) instead of wrapping; carry still pulses on the blocked
//   step as a limit indication.
// -----------------------------------------------------------------------------
module bcd_counter #(
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 1000000
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                en,
  input  logic                up_dn,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                tick_out,
  output logic                carry
);

  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       pre_q, pre_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                tick_q, tick_d;
  logic                carry_q, carry_d;

  logic                step;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] loaded;
  logic                prop;
  logic [3:0]          dig;
  logic                wrap;

  assign step = en && (pre_q == PRE_LAST);

  // Ripple increment/decrement across all digits. 'prop' carries the
  // increment (or decrement) into the next digit; if it survives past the
  // most significant digit, the whole counter wrapped.
  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stepped = bcd_q;
    prop    = 1'b1;
    dig     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bcd_q[4*i +: 4];
      if (prop) begin
        if (up_dn) begin
          if (dig == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = dig + 4'd1;
            prop              = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = dig - 4'd1;
            prop              = 1'b0;
          end
        end
      end
    end
    wrap = prop;
  end

  // Sanitise the load value so every stored digit stays in 0..9.
  always_comb begin
    loaded = '0;
    for (int i = 0; i < DIGITS; i++) begin
      loaded[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  // Next state: clr > load > step > hold.
  always_comb begin
    pre_d   = pre_q;
    bcd_d   = bcd_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (clr) begin
      pre_d = '0;
      bcd_d = '0;
    end else if (load) begin
      pre_d = '0;
      bcd_d = loaded;
    end else if (step) begin
      pre_d   = '0;
      tick_d  = 1'b1;
      carry_d = wrap;
`ifdef BCD_COUNTER_SATURATE_EN
      bcd_d   = wrap ? bcd_q : stepped;
`else
      bcd_d   = stepped;
`endif
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign tick_out = tick_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter
//
// Self-checking bench for bcd_counter (DIGITS=3, TICK_DIV=4). A reference
// model keeps the count as a plain integer 0..999 and the prescaler as an
// integer; outputs are compared every cycle on the falling edge. Directed
// sequences cover reset, wrap/borrow, invalid load, priority, enable gating
// and asynchronous reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_bcd_counter;

  localparam int DIGITS   = 3;
  localparam int TICK_DIV = 4;
  localparam int MAX_VAL  = 999;

  logic                clk_in;
  logic                reset;
  logic                en;
  logic                up_dn;
  logic                clr;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] bcd_out;
  logic                tick_out;
  logic                carry;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_val;
  int m_pre;
  bit m_tick;
  bit m_carry;

  bcd_counter #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .bcd_out  (bcd_out),
    .tick_out (tick_out),
    .carry    (carry)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [11:0] lv);
    int v;
    int w;
    int n;
    v = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 0;
      v = v + n * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_val   = 0;
    m_pre   = 0;
    m_tick  = 0;
    m_carry = 0;
  endtask

  // One rising edge of the reference model, using the inputs as driven.
  task automatic model_edge();
    m_tick  = 0;
    m_carry = 0;
    if (clr) begin
      m_val = 0;
      m_pre = 0;
    end else if (load) begin
      m_val = from_load(load_val);
      m_pre = 0;
    end else if (en && m_pre == TICK_DIV - 1) begin
      m_pre  = 0;
      m_tick = 1;
      if (up_dn) begin
        if (m_val == MAX_VAL) begin
          m_carry = 1;
`ifndef BCD_COUNTER_SATURATE_EN
          m_val = 0;
`endif
        end else begin
          m_val = m_val + 1;
        end
      end else begin
        if (m_val == 0) begin
          m_carry = 1;
`ifndef BCD_COUNTER_SATURATE_EN
          m_val = MAX_VAL;
`endif
        end else begin
          m_val = m_val - 1;
        end
      end
    end else if (en) begin
      m_pre = m_pre + 1;
    end
  endtask

  // Drive inputs, advance one clock, compare against the model.
  task automatic cycle(input logic e, input logic u, input logic c,
                       input logic l, input logic [11:0] lv);
    en       = e;
    up_dn    = u;
    clr      = c;
    load     = l;
    load_val = lv;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check("bcd_out",  32'(bcd_out),  32'(to_bcd(m_val)));
    check("tick_out", 32'(tick_out), 32'(m_tick));
    check("carry",    32'(carry),    32'(m_carry));
  endtask

  task automatic run(input int n, input logic e, input logic u);
    for (int k = 0; k < n; k++) cycle(e, u, 1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    model_reset();

    // 1. Reset and first step
    #12;
    check("rst_bcd",   32'(bcd_out),  32'h000);
    check("rst_tick",  32'(tick_out), 32'h0);
    check("rst_carry", 32'(carry),    32'h0);
    @(negedge clk_in);
    reset = 1'b1;
    check("rel_bcd", 32'(bcd_out), 32'h000);
    run(3, 1'b1, 1'b1);
    check("first_step_early", 32'(tick_out), 32'h0);
    run(1, 1'b1, 1'b1);
    check("first_step_tick", 32'(tick_out), 32'h1);
    check("first_step_bcd",  32'(bcd_out),  32'h001);
    run(4, 1'b1, 1'b1);
    check("second_step_bcd", 32'(bcd_out), 32'h002);

    // 2. Up wrap
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 12'h998);
    run(8, 1'b1, 1'b1);
`ifdef BCD_COUNTER_SATURATE_EN
    check("upwrap_bcd", 32'(bcd_out), 32'h999);
`else
    check("upwrap_bcd", 32'(bcd_out), 32'h000);
`endif
    check("upwrap_carry", 32'(carry), 32'h1);
    run(1, 1'b1, 1'b1);
    check("upwrap_carry_drop", 32'(carry), 32'h0);

    // 3. Down borrow
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 12'h100);
    run(4, 1'b1, 1'b0);
    check("borrow_bcd",   32'(bcd_out), 32'h099);
    check("borrow_carry", 32'(carry),   32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 12'h000);
    run(4, 1'b1, 1'b0);
`ifdef BCD_COUNTER_SATURATE_EN
    check("dnwrap_bcd", 32'(bcd_out), 32'h000);
`else
    check("dnwrap_bcd", 32'(bcd_out), 32'h999);
`endif
    check("dnwrap_carry", 32'(carry), 32'h1);

    // 4. Invalid load, prescaler restart
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 12'hA5F);
    check("badload_bcd", 32'(bcd_out), 32'h050);
    run(3, 1'b1, 1'b1);
    check("badload_no_tick", 32'(tick_out), 32'h0);
    run(1, 1'b1, 1'b1);
    check("badload_tick", 32'(tick_out), 32'h1);
    check("badload_step", 32'(bcd_out),  32'h051);

    // 5. Priority on a step edge
    run(3, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'h321);
    check("prio_clr_bcd",  32'(bcd_out),  32'h000);
    check("prio_clr_tick", 32'(tick_out), 32'h0);
    run(3, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 12'h321);
    check("prio_load_bcd",  32'(bcd_out),  32'h321);
    check("prio_load_tick", 32'(tick_out), 32'h0);
    run(3, 1'b1, 1'b1);
    check("prio_next_early", 32'(tick_out), 32'h0);
    run(1, 1'b1, 1'b1);
    check("prio_next_tick", 32'(tick_out), 32'h1);
    check("prio_next_bcd",  32'(bcd_out),  32'h322);

    // 6a. Enable gating mid-prescale
    run(2, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);
    check("gate_hold_bcd", 32'(bcd_out), 32'h322);
    run(1, 1'b1, 1'b1);
    check("gate_resume_early", 32'(tick_out), 32'h0);
    run(1, 1'b1, 1'b1);
    check("gate_resume_tick", 32'(tick_out), 32'h1);
    check("gate_resume_bcd",  32'(bcd_out),  32'h323);

    // 6b. Asynchronous reset between edges
    run(2, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_bcd",   32'(bcd_out),  32'h000);
    check("async_tick",  32'(tick_out), 32'h0);
    check("async_carry", 32'(carry),    32'h0);
    model_reset();
    #1;
    reset = 1'b1;
    run(3, 1'b1, 1'b1);
    check("async_first_early", 32'(tick_out), 32'h0);
    run(1, 1'b1, 1'b1);
    check("async_first_tick", 32'(tick_out), 32'h1);
    check("async_first_bcd",  32'(bcd_out),  32'h001);

    // Randomized phase against the model
    for (int k = 0; k < 1500; k++) begin
      logic r_en;
      logic r_up;
      logic r_clr;
      logic r_load;
      logic [11:0] r_lv;
      r_en   = ($urandom_range(9, 0) < 8);
      r_up   = ($urandom_range(63, 0) < 40) ? 1'b1 : (k[8] ? 1'b0 : 1'b1);
      r_clr  = ($urandom_range(59, 0) == 0);
      r_load = ($urandom_range(29, 0) == 0);
      r_lv   = 12'($urandom);
      cycle(r_en, r_up, r_clr, r_load, r_lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_counter.md
# bcd_counter

Multi-digit decimal up/down counter with a built-in tick prescaler. It produces packed BCD digits that feed the per-digit BCD-to-seven-segment decoders, one nibble per decoder. It sits directly upstream of the display path and runs from the board clock. It replaces ad-hoc divided clocks with a single-clock, enable-tick design.

## Interface
Parameters:
- DIGITS, 3: number of BCD digits (1..8).
- TICK_DIV, 1000000: enabled clk_in cycles per count step (>= 1).

Ports:
- clk_in  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); one clock.
- en  input  1  count enable; gates the prescaler.
- up_dn  input  1  1 = count up, 0 = count down; sampled on the step edge.
- clr  input  1  synchronous clear.
- load  input  1  synchronous load of load_val.
- load_val  input  4*DIGITS  load value; digit 0 is bits [3:0].
- bcd_out  output  4*DIGITS  current count, packed BCD; digit 0 is bits [3:0].
- tick_out  output  1  one-cycle pulse marking a count step.
- carry  output  1  one-cycle pulse on wrap (carry when up, borrow when down).

## Operation
- Prescaler: internal counter of width max(1, $clog2(TICK_DIV)), range 0..TICK_DIV-1.
  - step = en && (prescaler == TICK_DIV-1).
  - On step the prescaler returns to 0. Otherwise it increments when en=1 and holds when en=0.
- Priority at each rising edge: clr > load > step > hold.
  - clr: bcd_out←0, prescaler←0, tick_out←0, carry←0.
  - load: each digit of bcd_out←the matching nibble of load_val; any nibble >9 loads as 0. Also prescaler←0, tick_out←0, carry←0.
  - step, counting up: digit 0 increments. A digit at 9 becomes 0 and propagates an increment to the next digit. All digits at 9 → all 0, with carry←1.
  - step, counting down: digit 0 decrements. A digit at 0 becomes 9 and propagates a decrement to the next digit. All digits at 0 → all 9, with carry←1.
  - step always sets tick_out←1. Without a wrap, carry←0.
  - No step: tick_out←0, carry←0, bcd_out holds.
- Every digit of bcd_out stays in 0..9 at all times.
- up_dn changes take effect on the next step only. No glitch, and no extra step is produced.

## Timing
- Reset values: bcd_out=0, tick_out=0, carry=0, prescaler=0. Reset acts immediately on reset=0, independent of clk_in.
- Reset mid-count: state is discarded. After reset=1, the first step occurs TICK_DIV enabled cycles later.
- All outputs are registered. bcd_out, tick_out and carry change on the same edge, so tick_out/carry are high during the first cycle the new value is visible.
- Steps are spaced exactly TICK_DIV enabled cycles apart. Disabled cycles stretch the spacing without losing prescaler progress.
- TICK_DIV=1 with en held at 1: a step on every edge, and tick_out stays continuously 1.
- A load or clr on an edge that would have been a step suppresses that step. The next step comes TICK_DIV enabled cycles later.
- Combinational depth: the ripple across DIGITS digits completes within one cycle. No multicycle paths.

## Configuration
- BCD_COUNTER_SATURATE_EN:
  - Defined: counting up at all 9s holds at all 9s; counting down at all 0s holds at 0. carry pulses on the step that is blocked (limit indication). tick_out still pulses.
  - Undefined: wrap-around behaviour exactly as in Operation.

## Test plan
Bench parameters: DIGITS=3, TICK_DIV=4.
1. Reset and first step: drive reset=0, then release it. Hold en=1, up_dn=1.
   - bcd_out=12'h000 at release.
   - First tick_out pulse on the 4th edge after release, with bcd_out=12'h001.
   - Steps continue every 4 cycles after that.
2. Up wrap: load 12'h998, then count up 2 steps.
   - After 2 steps, bcd_out=12'h000 with carry=1 for one cycle.
   - With BCD_COUNTER_SATURATE_EN defined, bcd_out stays 12'h999 and carry=1 on the blocked step.
3. Down borrow: load 12'h100, up_dn=0, one step.
   - bcd_out=12'h099, carry=0.
   - Load 12'h000 and step: bcd_out=12'h999, carry=1.
4. Invalid load: load_val=12'hA5F.
   - bcd_out=12'h050 on the next cycle; prescaler restarts.
5. Priority: on a step edge, assert clr, load (12'h321) and en together.
   - bcd_out=12'h000, tick_out=0.
   - Repeat with load only: bcd_out=12'h321, tick_out=0, next step 4 enabled cycles later.
6. Enable gating and async reset:
   - Drop en for 10 cycles mid-prescale: no step occurs, and the remaining count resumes when en returns.
   - Pulse reset=0 between clock edges: all outputs read 0 immediately.
